// File: rtl/ray_march_scheduler.sv
// Pixel scheduler/collector for an array of ray-marching cores.
// Walks the frame in raster order, hands one pixel per cycle to a free and
// ready core (round-robin), holds each core's colour until it is retired and
// merges the results into one registered pixel stream.
//
// Ports:
//   clk_in, rst_n_in              clock, asynchronous active-low reset
//   start_in, fractal_sel_in      frame start request, fractal select (latched)
//   core_ready_in                 per-core accept indication
//   core_start_out                one-hot dispatch pulse
//   core_hcount/vcount_out        dispatched pixel coordinate
//   fractal_sel_out               fractal select of the current frame
//   core_done_in, core_color_in   per-core result pulse and colour lanes
//   hcount/vcount/color/valid_out retired pixel stream
//   new_frame_out                 pulse once all pixels of a frame retired
//   frame_count_out               completed frames (wrapping)
//   busy_out                      high whenever not idle
module ray_march_scheduler #(
  parameter int unsigned DISPLAY_WIDTH  = 320,
  parameter int unsigned DISPLAY_HEIGHT = 240,
  parameter int unsigned H_BITS         = 9,
  parameter int unsigned V_BITS         = 8,
  parameter int unsigned COLOR_BITS     = 4,
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned CONTINUOUS     = 1
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic [2:0]                      fractal_sel_in,
  input  logic [NUM_CORES-1:0]            core_ready_in,
  output logic [NUM_CORES-1:0]            core_start_out,
  output logic [H_BITS-1:0]               core_hcount_out,
  output logic [V_BITS-1:0]               core_vcount_out,
  output logic [2:0]                      fractal_sel_out,
  input  logic [NUM_CORES-1:0]            core_done_in,
  input  logic [NUM_CORES*COLOR_BITS-1:0] core_color_in,
  output logic [H_BITS-1:0]               hcount_out,
  output logic [V_BITS-1:0]               vcount_out,
  output logic [COLOR_BITS-1:0]           color_out,
  output logic                            valid_out,
  output logic                            new_frame_out,
  output logic [15:0]                     frame_count_out,
  output logic                            busy_out
);

  localparam int unsigned IdxW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned NumPix = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int unsigned CntW   = $clog2(NumPix + 1);
  localparam logic [H_BITS-1:0] XMax = H_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [V_BITS-1:0] YMax = V_BITS'(DISPLAY_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StDispatch, StDrain, StEnd} state_e;
  typedef enum logic [1:0] {SlotFree, SlotBusy, SlotHeld} slot_e;

  state_e                state_q, state_d;
  slot_e                 slot_q   [NUM_CORES];
  logic [H_BITS-1:0]     slot_x_q [NUM_CORES];
  logic [V_BITS-1:0]     slot_y_q [NUM_CORES];
  logic [COLOR_BITS-1:0] slot_c_q [NUM_CORES];

  logic [H_BITS-1:0]     cur_x_q;
  logic [V_BITS-1:0]     cur_y_q;
  logic [IdxW-1:0]       last_disp_q, last_ret_q;
  logic [CntW-1:0]       ret_cnt_q;
  logic [2:0]            fsel_q;
  logic [15:0]           frame_cnt_q;
  logic                  new_frame_q;
  logic                  valid_q;
  logic [H_BITS-1:0]     hcount_q;
  logic [V_BITS-1:0]     vcount_q;
  logic [COLOR_BITS-1:0] color_q;
  logic [NUM_CORES-1:0]  core_start_q;
  logic [H_BITS-1:0]     core_h_q;
  logic [V_BITS-1:0]     core_v_q;

  logic            disp_found, ret_found, all_free;
  logic [IdxW-1:0] disp_idx, ret_idx;
  logic            dispatch_en, last_pix, start_frame, end_frame;
  int unsigned     cand;

  // Round-robin pickers: dispatch starts one past the last dispatched core,
  // collection one past the last retired slot. A slot retiring this cycle is
  // still HELD, so it can never be re-dispatched on the same edge.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    ret_found  = 1'b0;
    ret_idx    = '0;
    all_free   = 1'b1;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = (32'(last_disp_q) + k + 1) % NUM_CORES;
      if (!disp_found && slot_q[IdxW'(cand)] == SlotFree && core_ready_in[IdxW'(cand)]) begin
        disp_found = 1'b1;
        disp_idx   = IdxW'(cand);
      end
    end
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = (32'(last_ret_q) + k + 1) % NUM_CORES;
      if (!ret_found && slot_q[IdxW'(cand)] == SlotHeld) begin
        ret_found = 1'b1;
        ret_idx   = IdxW'(cand);
      end
    end
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (slot_q[k] != SlotFree) all_free = 1'b0;
    end
  end

  assign dispatch_en = (state_q == StDispatch) && disp_found;
  assign last_pix    = (cur_x_q == XMax) && (cur_y_q == YMax);

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d     = StDispatch;
          start_frame = 1'b1;
        end
      end
      StDispatch: begin
        if (dispatch_en && last_pix) state_d = StDrain;
      end
      StDrain: begin
        if (all_free && !ret_found && ret_cnt_q == CntW'(NumPix)) begin
          state_d   = StEnd;
          end_frame = 1'b1;
        end
      end
      StEnd: begin
        if (CONTINUOUS != 0) begin
          state_d     = StDispatch;
          start_frame = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      last_disp_q  <= IdxW'(NUM_CORES - 1);
      last_ret_q   <= IdxW'(NUM_CORES - 1);
      ret_cnt_q    <= '0;
      fsel_q       <= '0;
      frame_cnt_q  <= '0;
      new_frame_q  <= 1'b0;
      valid_q      <= 1'b0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      color_q      <= '0;
      core_start_q <= '0;
      core_h_q     <= '0;
      core_v_q     <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_q[i]   <= SlotFree;
        slot_x_q[i] <= '0;
        slot_y_q[i] <= '0;
        slot_c_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      core_start_q <= '0;
      valid_q      <= 1'b0;
      new_frame_q  <= end_frame;

      if (start_frame) begin
        fsel_q    <= fractal_sel_in;
        cur_x_q   <= '0;
        cur_y_q   <= '0;
        ret_cnt_q <= '0;
      end
      if (end_frame) frame_cnt_q <= frame_cnt_q + 16'd1;

      if (dispatch_en) begin
        core_start_q[disp_idx] <= 1'b1;
        core_h_q               <= cur_x_q;
        core_v_q               <= cur_y_q;
        slot_q[disp_idx]       <= SlotBusy;
        slot_x_q[disp_idx]     <= cur_x_q;
        slot_y_q[disp_idx]     <= cur_y_q;
        last_disp_q            <= disp_idx;
        if (cur_x_q == XMax) begin
          cur_x_q <= '0;
          cur_y_q <= cur_y_q + V_BITS'(1);
        end else begin
          cur_x_q <= cur_x_q + H_BITS'(1);
        end
      end

      if (ret_found) begin
        valid_q         <= 1'b1;
        hcount_q        <= slot_x_q[ret_idx];
        vcount_q        <= slot_y_q[ret_idx];
        color_q         <= slot_c_q[ret_idx];
        slot_q[ret_idx] <= SlotFree;
        last_ret_q      <= ret_idx;
        ret_cnt_q       <= ret_cnt_q + CntW'(1);
      end

      // Done pulses only count on BUSY slots; stale pulses after a reset or
      // on HELD slots fall through.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_done_in[i] && slot_q[i] == SlotBusy) begin
          slot_q[i]   <= SlotHeld;
          slot_c_q[i] <= core_color_in[i*COLOR_BITS +: COLOR_BITS];
        end
      end
    end
  end

  assign core_start_out  = core_start_q;
  assign core_hcount_out = core_h_q;
  assign core_vcount_out = core_v_q;
  assign fractal_sel_out = fsel_q;
  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign color_out       = color_q;
  assign valid_out       = valid_q;
  assign new_frame_out   = new_frame_q;
  assign frame_count_out = frame_cnt_q;
  assign busy_out        = (state_q != StIdle);

endmodule

// File: tb/tb_ray_march_scheduler.sv
// Self-checking bench for ray_march_scheduler on a 4x2 frame with two cores.
// A behavioural model tracks each core as free / computing / holding a
// result and predicts dispatch, retire, frame-end and counter behaviour.
module tb_ray_march_scheduler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = 2;
  localparam int CB = 4;
  localparam int HB = 9;
  localparam int VB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start_in;
  logic [2:0]    fsel_in;
  logic [N-1:0]  core_ready_in, core_done_in;
  logic [N*CB-1:0] core_color_in;
  logic [N-1:0]  core_start_out;
  logic [HB-1:0] core_hcount_out, hcount_out;
  logic [VB-1:0] core_vcount_out, vcount_out;
  logic [2:0]    fsel_out;
  logic [CB-1:0] color_out;
  logic          valid_out, new_frame_out, busy_out;
  logic [15:0]   frame_count_out;

  ray_march_scheduler #(
    .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB),
    .COLOR_BITS(CB), .NUM_CORES(N), .CONTINUOUS(0)
  ) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_in), .fractal_sel_in(fsel_in),
    .core_ready_in(core_ready_in), .core_start_out(core_start_out),
    .core_hcount_out(core_hcount_out), .core_vcount_out(core_vcount_out),
    .fractal_sel_out(fsel_out), .core_done_in(core_done_in), .core_color_in(core_color_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .color_out(color_out),
    .valid_out(valid_out), .new_frame_out(new_frame_out),
    .frame_count_out(frame_count_out), .busy_out(busy_out)
  );

  // Continuous-mode instance: cores always ready, answer one cycle later.
  logic          c_rst_n, c_start;
  logic [2:0]    c_fsel_in, c_fsel_out;
  logic [N-1:0]  c_ready, c_done, c_core_start;
  logic [N*CB-1:0] c_color_in;
  logic [HB-1:0] c_core_h, c_h;
  logic [VB-1:0] c_core_v, c_v;
  logic [CB-1:0] c_color;
  logic          c_valid, c_nf, c_busy;
  logic [15:0]   c_fc;

  assign c_ready    = 2'b11;
  assign c_done     = c_core_start;
  assign c_color_in = 8'h5A;

  ray_march_scheduler #(
    .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB),
    .COLOR_BITS(CB), .NUM_CORES(N), .CONTINUOUS(1)
  ) u_dut_cont (
    .clk_in(clk), .rst_n_in(c_rst_n), .start_in(c_start), .fractal_sel_in(c_fsel_in),
    .core_ready_in(c_ready), .core_start_out(c_core_start),
    .core_hcount_out(c_core_h), .core_vcount_out(c_core_v),
    .fractal_sel_out(c_fsel_out), .core_done_in(c_done), .core_color_in(c_color_in),
    .hcount_out(c_h), .vcount_out(c_v), .color_out(c_color),
    .valid_out(c_valid), .new_frame_out(c_nf),
    .frame_count_out(c_fc), .busy_out(c_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state
  bit       busy_c [N];
  bit       pend   [N];
  bit       held   [N];
  int       tmr    [N];
  int       bx [N], by [N], hx [N], hy [N];
  logic [3:0] hc [N];
  int       lat [N];
  int       ex, ey, n_disp, n_ret, last_d, last_r, frames, wait_arm, vcnt, stall;
  bit       dispatching, nf_arm, busy_exp, end_seen, rand_ready, req_start;
  bit       prev_valid, consec;
  logic [2:0] fsel_exp, req_fsel;
  int       last_h, last_v, last_c, first_h, first_v;
  logic [N-1:0] spur;

  function automatic logic [3:0] colf(input int x, input int y, input int c);
    int t;
    t = x * 5 + y * 3 + c * 7 + 1;
    return t[3:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      busy_c[i] = 0; pend[i] = 0; held[i] = 0; tmr[i] = 0;
    end
    ex = 0; ey = 0; n_disp = 0; n_ret = 0; last_d = N - 1; last_r = N - 1;
    frames = 0; wait_arm = 0; vcnt = 0; dispatching = 0; nf_arm = 0;
    busy_exp = 0; end_seen = 0; req_start = 0; fsel_exp = '0;
    last_h = 0; last_v = 0; last_c = 0; prev_valid = 0; spur = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_core_start"}, 32'(core_start_out), 0);
    chk({tag, "_core_hv"}, {core_hcount_out, core_vcount_out}, 0);
    chk({tag, "_pixel"}, {hcount_out, vcount_out, color_out}, 0);
    chk({tag, "_flags"}, {valid_out, new_frame_out, busy_out, fsel_out}, 0);
    chk({tag, "_frame_count"}, 32'(frame_count_out), 0);
  endtask

  task automatic step();
    int ch, i;
    logic [N-1:0] exp_s, dn;
    logic [N*CB-1:0] cc;
    @(posedge clk);
    #1;
    if (end_seen) begin
      busy_exp = 0;
      end_seen = 0;
    end
    // Dispatch: first free and ready core after the last dispatched one.
    exp_s = '0;
    ch = -1;
    if (wait_arm > 0) begin
      wait_arm = 0;
      dispatching = 1;
    end else if (dispatching) begin
      for (int k = 0; k < N; k++) begin
        i = (last_d + 1 + k) % N;
        if (ch < 0 && !busy_c[i] && !held[i] && core_ready_in[i]) ch = i;
      end
    end
    if (ch >= 0) exp_s[ch] = 1'b1;
    chk("core_start", 32'(core_start_out), 32'(exp_s));
    if (ch >= 0) begin
      chk("core_hcount", 32'(core_hcount_out), ex);
      chk("core_vcount", 32'(core_vcount_out), ey);
      busy_c[ch] = 1; bx[ch] = ex; by[ch] = ey; tmr[ch] = lat[ch]; last_d = ch;
      n_disp++;
      if (ex == W - 1) begin ex = 0; ey++; end else ex++;
      if (n_disp == W * H) dispatching = 0;
    end
    // Frame end follows the final retire by one cycle.
    chk("new_frame", 32'(new_frame_out), 32'(nf_arm));
    if (nf_arm) begin
      frames++;
      chk("frame_pixels", vcnt, W * H);
      vcnt = 0;
      end_seen = 1;
      nf_arm = 0;
    end
    chk("frame_count", 32'(frame_count_out), frames);
    chk("busy", 32'(busy_out), 32'(busy_exp));
    chk("fractal_sel", 32'(fsel_out), 32'(fsel_exp));
    // Collect: first holding core after the last retired one.
    ch = -1;
    for (int k = 0; k < N; k++) begin
      i = (last_r + 1 + k) % N;
      if (ch < 0 && held[i]) ch = i;
    end
    if (valid_out === 1'b1) begin
      if (vcnt == 0) begin first_h = int'(hcount_out); first_v = int'(vcount_out); end
      vcnt++;
    end
    chk("valid", 32'(valid_out), 32'(ch >= 0));
    if (ch >= 0) begin
      chk("hcount", 32'(hcount_out), hx[ch]);
      chk("vcount", 32'(vcount_out), hy[ch]);
      chk("color", 32'(color_out), 32'(hc[ch]));
      last_h = hx[ch]; last_v = hy[ch]; last_c = int'(hc[ch]);
      held[ch] = 0; last_r = ch; n_ret++;
      if (n_ret == W * H) nf_arm = 1;
      if (prev_valid) consec = 1;
    end else begin
      chk("hold_pixel", {hcount_out, vcount_out, color_out},
          {HB'(last_h), VB'(last_v), CB'(last_c)});
    end
    prev_valid = (ch >= 0);
    for (int k = 0; k < N; k++) begin
      if (pend[k]) begin
        held[k] = 1; hx[k] = bx[k]; hy[k] = by[k]; hc[k] = colf(bx[k], by[k], k);
        busy_c[k] = 0; pend[k] = 0;
      end
    end
    // Drive inputs for the next edge.
    dn = spur;
    spur = '0;
    cc = (N * CB)'($urandom);
    for (int k = 0; k < N; k++) begin
      if (busy_c[k] && !pend[k] && tmr[k] > 0) begin
        tmr[k]--;
        if (tmr[k] == 0) begin
          dn[k] = 1'b1;
          pend[k] = 1;
          cc[k*CB +: CB] = colf(bx[k], by[k], k);
        end
      end
    end
    core_done_in  = dn;
    core_color_in = cc;
    if (stall > 0) begin
      core_ready_in = '0;
      stall--;
    end else if (rand_ready) begin
      core_ready_in = N'($urandom_range(0, 3));
    end else begin
      core_ready_in = '1;
    end
    if (req_start && !busy_exp) begin
      start_in = 1'b1;
      fsel_in = req_fsel;
      fsel_exp = req_fsel;
      busy_exp = 1; wait_arm = 1; req_start = 0;
      n_disp = 0; n_ret = 0; ex = 0; ey = 0; vcnt = 0;
    end else begin
      start_in = 1'b0;
      fsel_in = 3'($urandom);
    end
  endtask

  task automatic start_frame(input logic [2:0] f);
    req_start = 1;
    req_fsel = f;
  endtask

  task automatic finish_frame(input int target);
    for (int c = 0; c < 400; c++) begin
      if (frames == target && !busy_exp && !end_seen && !req_start) break;
      step();
    end
    chk("frame_complete", frames, target);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    start_in = 1'b0;
    core_ready_in = '1;
    core_done_in = '1; // stale done pulses on free slots
  endtask

  int nfc, cval;

  initial begin
    rst_n = 1'b0; c_rst_n = 1'b0; c_start = 1'b0; c_fsel_in = '0;
    start_in = 1'b0; fsel_in = '0; core_ready_in = '0; core_done_in = '0;
    core_color_in = '0; stall = 0; rand_ready = 0; consec = 0;
    lat[0] = 3; lat[1] = 3;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    core_ready_in = '1;

    // Basic frame, equal latencies.
    start_frame(3'd2);
    finish_frame(1);
    repeat (3) step();

    // Out-of-order retire: (1,0) comes back before (0,0).
    lat[0] = 10; lat[1] = 1;
    start_frame(3'd6);
    finish_frame(2);
    chk("first_retire", {first_h[15:0], first_v[15:0]}, {16'd1, 16'd0});

    // Ready withdrawn mid-frame for 20 cycles.
    lat[0] = 2; lat[1] = 2;
    start_frame(3'd1);
    repeat (4) step();
    stall = 20;
    finish_frame(3);

    // Spurious done on idle cores, then two results landing together.
    spur = 2'b01;
    repeat (4) step();
    spur = 2'b11;
    repeat (4) step();
    lat[0] = 3; lat[1] = 2;
    consec = 0;
    start_frame(3'd4);
    finish_frame(4);
    chk("back_to_back_retire", 32'(consec), 1);

    // Randomised readiness and latencies.
    rand_ready = 1;
    for (int f = 0; f < 4; f++) begin
      lat[0] = $urandom_range(1, 6);
      lat[1] = $urandom_range(1, 6);
      start_frame(3'($urandom_range(0, 7)));
      finish_frame(5 + f);
    end
    rand_ready = 0;

    // Reset in the middle of dispatch, then a clean frame.
    lat[0] = 2; lat[1] = 3;
    start_frame(3'd7);
    repeat (4) step();
    do_reset("midreset");
    repeat (3) step();
    start_frame(3'd5);
    finish_frame(1);

    // Continuous instance: fractal select relatches per frame.
    @(posedge clk);
    #1;
    c_rst_n = 1'b1;
    c_start = 1'b1;
    c_fsel_in = 3'd3;
    nfc = 0;
    cval = 0;
    for (int c = 0; c < 200 && nfc < 2; c++) begin
      @(posedge clk);
      #1;
      c_start = 1'b0;
      if (c == 5) c_fsel_in = 3'd5;
      if (c_core_start != '0) begin
        chk("c_dispatch_onehot", 32'($onehot(c_core_start)), 1);
        chk("c_dispatch_range", 32'(c_core_h < HB'(W) && c_core_v < VB'(H)), 1);
      end
      if (c_valid === 1'b1) begin
        cval++;
        chk("c_color", 32'(c_color == 4'hA || c_color == 4'h5), 1);
        chk("c_pixel_range", 32'(c_h < HB'(W) && c_v < VB'(H)), 1);
      end
      if (c_nf === 1'b1) begin
        nfc++;
        chk("c_frame_pixels", cval, W * H);
        chk("c_frame_count", 32'(c_fc), nfc);
        chk("c_fractal_sel", 32'(c_fsel_out), (nfc == 1) ? 3 : 5);
        chk("c_busy", 32'(c_busy), 1);
        cval = 0;
      end
    end
    chk("c_two_frames", nfc, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ray_march_scheduler.md
Name: ray_march_scheduler

Overview:
- Parametrised pixel scheduler/collector between the frame controller and an array of NUM_CORES ray-marching cores.
- Walks the frame in raster order and hands one pixel coordinate per cycle to free cores, round-robin.
- Holds each core's colour result until it retires, then merges all results into one registered pixel stream (hcount/vcount/color/valid).
- Adds what the single-core path lacks: per-frame fractal_sel latching, continuous or single-shot frames, a frame counter, and a one-cycle new_frame pulse when the final pixel retires.

Parameters:
DISPLAY_WIDTH, 320, pixels per line
DISPLAY_HEIGHT, 240, lines per frame
H_BITS, 9, hcount width (>= clog2(DISPLAY_WIDTH))
V_BITS, 8, vcount width (>= clog2(DISPLAY_HEIGHT))
COLOR_BITS, 4, colour width per pixel
NUM_CORES, 4, number of marching cores (1..16)
CONTINUOUS, 1, 1 = restart the next frame automatically; 0 = wait for start_in

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
start_in  in  1  begin a frame when in IDLE (level is sufficient)
fractal_sel_in  in  3  fractal select, sampled at frame start
core_ready_in  in  NUM_CORES  core i can accept a pixel
core_start_out  out  NUM_CORES  one-hot, 1-cycle pulse dispatching the current pixel
core_hcount_out  out  H_BITS  dispatched pixel x, valid with core_start_out
core_vcount_out  out  V_BITS  dispatched pixel y, valid with core_start_out
fractal_sel_out  out  3  latched fractal select for the current frame
core_done_in  in  NUM_CORES  1-cycle pulse: core i result valid
core_color_in  in  NUM_CORES*COLOR_BITS  core i colour at bits [i*COLOR_BITS +: COLOR_BITS]
hcount_out  out  H_BITS  retired pixel x
vcount_out  out  V_BITS  retired pixel y
color_out  out  COLOR_BITS  retired pixel colour
valid_out  out  1  retired pixel valid (1 cycle per pixel)
new_frame_out  out  1  1-cycle pulse: every pixel of the frame has retired
frame_count_out  out  16  completed frames, wraps at 2^16
busy_out  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync-release assumed upstream): all outputs 0, FSM IDLE, all slots FREE, cursor (0,0), frame_count 0. Asserting reset mid-frame abandons the frame. Core done pulses arriving after reset are ignored, because their slots are FREE.
- FSM:
  - IDLE -> DISPATCH when start_in=1. On this edge: latch fractal_sel_out and set the cursor to (0,0).
  - DISPATCH -> DRAIN on the edge that dispatches the pixel (DISPLAY_WIDTH-1, DISPLAY_HEIGHT-1).
  - DRAIN -> END when all slots are FREE and no retire is pending.
  - END, one cycle: pulse new_frame_out and increment frame_count. Then go to DISPATCH if CONTINUOUS=1 (relatch fractal_sel, cursor (0,0)), otherwise to IDLE.
- Per-core slot states:
  - FREE -> BUSY on dispatch. The slot stores the dispatched x,y.
  - BUSY -> HELD on core_done_in[i]. The slot captures the colour.
  - HELD -> FREE when the collector retires the slot.
  - core_done_in on a FREE or HELD slot is ignored.
- Dispatch:
  - In DISPATCH, each cycle select the first core i with slot FREE and core_ready_in[i]=1, searching round-robin from one past the last dispatched core.
  - Registered output: core_start_out[i], core_hcount_out and core_vcount_out appear the cycle after selection. The slot goes BUSY and the cursor advances on the selecting edge.
  - Cursor advance: x+1; at x=DISPLAY_WIDTH-1, x wraps to 0 and y+1. No dispatch occurs when no core qualifies.
  - Maximum one dispatch per cycle.
- Collect:
  - Each cycle, choose the first HELD slot round-robin from one past the last retired slot.
  - Next cycle: valid_out=1 with that slot's x, y and colour. The slot goes FREE on the choosing edge.
  - Maximum one retire per cycle. Pixels may retire out of raster order.
  - Between retires, the last hcount/vcount/color values are held and valid_out=0.
- Simultaneous events on one core:
  - Retire and dispatch of the same core in one cycle is not allowed: a retiring slot is not FREE until the next edge.
  - A done pulse on one core while another retires is accepted.
- Counting: retired-pixel counter width = clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT+1). DRAIN exits only when the count equals DISPLAY_WIDTH*DISPLAY_HEIGHT.
- start_in is ignored outside IDLE. fractal_sel_in changes mid-frame have no effect until the next frame start.

Test Plan:
- WIDTH=4, HEIGHT=2, NUM_CORES=2, cores done 3 cycles after start, CONTINUOUS=0, start_in pulse -> core_start_out alternates 01,10 starting one cycle after start. Exactly 8 valid_out pulses covering every (x,y) in 0..3 × 0..1 once. new_frame_out pulses once, frame_count_out=1, FSM returns to IDLE, busy_out=0.
- Core 1 latency 1 cycle, core 0 latency 10 cycles -> pixels retire out of order, with (0,0) not first. All 8 pixels still appear once, with colour = core's colour for its stored coordinate. new_frame_out is only after the last retire.
- core_ready_in=00 for 20 cycles mid-frame -> no core_start_out, cursor frozen. After ready returns, dispatch resumes at the next unissued pixel with no skip or duplicate.
- CONTINUOUS=1, fractal_sel_in=3 at the first start, changed to 5 mid-frame -> fractal_sel_out=3 for frame 1 and 5 for frame 2. frame_count_out=2 after the second new_frame_out.
- Spurious core_done_in on a FREE core -> no valid_out generated. Both cores done in the same cycle -> two valid_out on consecutive cycles.
- rst_n_in asserted low mid-DISPATCH for 1 cycle -> all outputs 0 immediately. After release, idles until start_in, then renders a full 8-pixel frame with frame_count_out=1.
